// File: rtl/gamma_seq_ctrl_pkg.sv
// Shared types and width helpers for the gamma-cycle sequencer and its spike encoders.
package gamma_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } gamma_state_e;

  function automatic int val_w(input int g);
    return $clog2(g) + 1;
  endfunction

  function automatic int t_w(input int g);
    return $clog2(g);
  endfunction

  // Any operand at or above this code never spikes within the gamma cycle.
  function automatic int inf_code(input int g);
    return g;
  endfunction

endpackage

// File: rtl/gamma_seq_ctrl_if.sv
// Host handshakes plus the race-logic compare-unit link of the gamma sequencer.
interface gamma_seq_ctrl_if #(
  parameter int VAL_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [VAL_W-1:0] in_a;
  logic [VAL_W-1:0] in_b;
  logic             unit_rst;
  logic             unit_a;
  logic             unit_b;
  logic             unit_y;
  logic             out_valid;
  logic             out_ready;
  logic [VAL_W-1:0] out_time;
  logic             out_none;

  modport master (
    input  in_valid, in_a, in_b, unit_y, out_ready,
    output in_ready, unit_rst, unit_a, unit_b, out_valid, out_time, out_none
  );

  modport slave (
    output in_valid, in_a, in_b, unit_y, out_ready,
    input  in_ready, unit_rst, unit_a, unit_b, out_valid, out_time, out_none
  );
endinterface

// File: rtl/gamma_seq_ctrl_encoder.sv
// Turns a binary spike time into a PULSE_WIDTH-tick pulse, truncated at the gamma-cycle end.
module temporal_encoder
  import gamma_pkg::*;
#(
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int PULSE_WIDTH       = 8
) (
  input  logic [val_w(GAMMA_CYCLE_WIDTH)-1:0] i_value,
  input  logic [t_w(GAMMA_CYCLE_WIDTH)-1:0]   i_tick,
  input  logic                                i_run,
  output logic                                o_spike
);
  localparam int VAL_W = val_w(GAMMA_CYCLE_WIDTH);
  // Widened so value + PULSE_WIDTH never wraps.
  localparam int CW    = VAL_W + $clog2(PULSE_WIDTH) + 1;

  logic [CW-1:0] w_value;
  logic [CW-1:0] w_tick;
  logic [CW-1:0] w_end;

  assign w_value = CW'(i_value);
  assign w_tick  = CW'(i_tick);
  assign w_end   = w_value + CW'(PULSE_WIDTH);

  assign o_spike = i_run
                 & (w_value < CW'(inf_code(GAMMA_CYCLE_WIDTH)))
                 & (w_value <= w_tick)
                 & (w_tick < w_end);
endmodule

// File: rtl/gamma_seq_ctrl.sv
// Runs one compare unit through a gamma cycle: clear, replay operand spikes, timestamp unit_y.
module gamma_seq_ctrl
  import gamma_pkg::*;
#(
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int PULSE_WIDTH       = 8
) (
  input  logic              aclk,
  input  logic              grst,
  gamma_seq_ctrl_if.master  bus
);
  localparam int VAL_W = val_w(GAMMA_CYCLE_WIDTH);
  localparam int T_W   = t_w(GAMMA_CYCLE_WIDTH);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_CLEAR = CLEAR;
  localparam logic [1:0] ST_RUN   = RUN;
  localparam logic [1:0] ST_DONE  = DONE;

  logic [1:0]       r_state;
  logic [T_W-1:0]   r_tick;
  logic             r_seen;
  logic [VAL_W-1:0] r_time;
  logic             r_unit_rst;
  logic [VAL_W-1:0] r_a;
  logic [VAL_W-1:0] r_b;

  logic w_accept;
  logic w_run;
  logic w_last_tick;

  assign w_accept    = (r_state == ST_IDLE) & bus.in_valid;
  assign w_run       = (r_state == ST_RUN);
  assign w_last_tick = (r_tick == T_W'(GAMMA_CYCLE_WIDTH - 1));

  always_ff @(posedge aclk) begin
    if (grst) begin
      r_state    <= ST_IDLE;
      r_tick     <= '0;
      r_seen     <= 1'b0;
      r_time     <= '0;
      r_unit_rst <= 1'b1;
    end else begin
      r_unit_rst <= w_accept;
      case (r_state)
        ST_IDLE:  if (w_accept) r_state <= ST_CLEAR;
        ST_CLEAR: begin
          r_state <= ST_RUN;
          r_tick  <= '0;
          r_seen  <= 1'b0;
          r_time  <= '0;
        end
        ST_RUN: begin
          // Only the first assertion of unit_y carries the result.
          if (bus.unit_y && !r_seen) begin
            r_time <= VAL_W'(r_tick);
            r_seen <= 1'b1;
          end
          r_tick <= r_tick + 1'b1;
          if (w_last_tick) r_state <= ST_DONE;
        end
        ST_DONE:  if (bus.out_ready) r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (w_accept && !grst) begin
      r_a <= bus.in_a;
      r_b <= bus.in_b;
    end
  end

  temporal_encoder #(
    .GAMMA_CYCLE_WIDTH (GAMMA_CYCLE_WIDTH),
    .PULSE_WIDTH       (PULSE_WIDTH)
  ) u_enc_a (
    .i_value (r_a),
    .i_tick  (r_tick),
    .i_run   (w_run),
    .o_spike (bus.unit_a)
  );

  temporal_encoder #(
    .GAMMA_CYCLE_WIDTH (GAMMA_CYCLE_WIDTH),
    .PULSE_WIDTH       (PULSE_WIDTH)
  ) u_enc_b (
    .i_value (r_b),
    .i_tick  (r_tick),
    .i_run   (w_run),
    .o_spike (bus.unit_b)
  );

  assign bus.in_ready  = (r_state == ST_IDLE);
  assign bus.unit_rst  = r_unit_rst;
  assign bus.out_valid = (r_state == ST_DONE);
  assign bus.out_none  = (r_state == ST_DONE) & ~r_seen;
  assign bus.out_time  = r_time;

endmodule

// File: tb/tb_gamma_seq_ctrl.sv
// Bench for gamma_seq_ctrl: directed scenarios plus random operand pairs against a result model.
module tb_gamma_seq_ctrl;
  localparam int G  = 16;
  localparam int PW = 8;
  localparam int VW = 5;

  logic aclk = 1'b0;
  logic grst;
  bit   y_or;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 aclk = ~aclk;

  gamma_seq_ctrl_if #(.VAL_W(VW)) bus ();

  // Stateless compare unit: AND of spikes gives max, OR gives min.
  assign bus.unit_y = y_or ? (bus.unit_a | bus.unit_b) : (bus.unit_a & bus.unit_b);

  gamma_seq_ctrl #(
    .GAMMA_CYCLE_WIDTH (G),
    .PULSE_WIDTH       (PW)
  ) dut (
    .aclk (aclk),
    .grst (grst),
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit spike_at(input int v, input int t);
    return (v < G) && (t >= v) && (t - v < PW);
  endfunction

  // Result from race-logic rules: min for OR, max for AND (pulses must overlap).
  task automatic ref_result(input int a, input int b, input bit orm,
                            output int tm, output bit none);
    int lo, hi;
    lo = (a < b) ? a : b;
    hi = (a < b) ? b : a;
    tm = 0;
    none = 1'b1;
    if (orm) begin
      if (lo < G) begin tm = lo; none = 1'b0; end
    end else if (hi < G && hi < lo + PW) begin
      tm = hi; none = 1'b0;
    end
  endtask

  task automatic do_op(input int a, input int b, input bit orm, input int stall, input int abort);
    int tm;
    bit none;
    logic [VW-1:0] va, vb;
    ref_result(a, b, orm, tm, none);
    va = VW'(a);
    vb = VW'(b);
    y_or          = orm;
    bus.in_a      = va;
    bus.in_b      = vb;
    bus.in_valid  = 1'b1;
    bus.out_ready = (stall == 0);
    chk("in_ready_idle", 32'(bus.in_ready), 1);
    @(negedge aclk);
    bus.in_valid = 1'b0;
    bus.in_a     = VW'($urandom);
    bus.in_b     = VW'($urandom);
    chk("unit_rst_clear", 32'(bus.unit_rst), 1);
    chk("in_ready_clear", 32'(bus.in_ready), 0);
    chk("unit_a_clear", 32'(bus.unit_a), 0);
    for (int t = 0; t < G; t++) begin
      @(negedge aclk);
      chk("unit_rst_run", 32'(bus.unit_rst), 0);
      chk("unit_a_run", 32'(bus.unit_a), 32'(spike_at(a, t)));
      chk("unit_b_run", 32'(bus.unit_b), 32'(spike_at(b, t)));
      chk("out_valid_run", 32'(bus.out_valid), 0);
      if (t == abort) begin
        grst = 1'b1;
        @(negedge aclk);
        grst = 1'b0;
        chk("abort_unit_a", 32'(bus.unit_a), 0);
        chk("abort_unit_b", 32'(bus.unit_b), 0);
        chk("abort_unit_rst", 32'(bus.unit_rst), 1);
        chk("abort_out_valid", 32'(bus.out_valid), 0);
        chk("abort_in_ready", 32'(bus.in_ready), 1);
        for (int k = 0; k < G + 4; k++) begin
          @(negedge aclk);
          chk("abort_no_result", 32'(bus.out_valid), 0);
        end
        return;
      end
    end
    @(negedge aclk);
    for (int k = 0; k <= stall; k++) begin
      chk("out_valid", 32'(bus.out_valid), 1);
      chk("out_time", 32'(bus.out_time), 32'(tm));
      chk("out_none", 32'(bus.out_none), 32'(none));
      chk("in_ready_done", 32'(bus.in_ready), 0);
      if (k < stall) begin
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.in_a     = VW'($urandom);
        bus.in_b     = VW'($urandom);
      end else begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
      end
      @(negedge aclk);
    end
    chk("out_valid_after", 32'(bus.out_valid), 0);
    chk("in_ready_after", 32'(bus.in_ready), 1);
  endtask

  initial begin
    grst          = 1'b1;
    y_or          = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;
    repeat (2) begin
      @(negedge aclk);
      chk("rst_unit_rst", 32'(bus.unit_rst), 1);
      chk("rst_out_valid", 32'(bus.out_valid), 0);
      chk("rst_unit_a", 32'(bus.unit_a), 0);
      chk("rst_unit_b", 32'(bus.unit_b), 0);
      chk("rst_out_time", 32'(bus.out_time), 0);
      chk("rst_out_none", 32'(bus.out_none), 0);
    end
    grst = 1'b0;
    @(negedge aclk);
    chk("rel_unit_rst", 32'(bus.unit_rst), 0);
    chk("rel_in_ready", 32'(bus.in_ready), 1);

    // in_valid together with grst must not start an op
    grst         = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_a     = 5'd3;
    @(negedge aclk);
    chk("rstv_unit_rst", 32'(bus.unit_rst), 1);
    grst         = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge aclk);
    chk("rstv_in_ready", 32'(bus.in_ready), 1);
    chk("rstv_unit_rst_low", 32'(bus.unit_rst), 0);

    do_op(3, 5, 1'b0, 0, -1);
    do_op(2, 12, 1'b0, 0, -1);
    do_op(16, 4, 1'b0, 0, -1);
    do_op(16, 4, 1'b1, 0, -1);
    do_op(7, 9, 1'b1, 5, -1);
    do_op(3, 5, 1'b0, 0, 7);
    do_op(1, 1, 1'b0, 0, -1);
    do_op(15, 15, 1'b1, 1, -1);

    for (int i = 0; i < 30; i++) begin
      do_op($urandom_range(0, 2 * G - 1), $urandom_range(0, G), 1'($urandom_range(0, 1)),
            $urandom_range(0, 3), ($urandom_range(0, 9) == 0) ? $urandom_range(0, G - 1) : -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
